// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter sharing one generic bus among NUM_REQ requesters.
// Zero-cycle grant from IDLE; the grant is held until completion or abort.
module generic_bus_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic [NUM_REQ-1:0]      req_ren,
   input  logic [NUM_REQ-1:0]      req_wen,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   input  logic [NUM_REQ*4-1:0]    req_byte_en,
   output logic [NUM_REQ-1:0]      req_busy,
   output logic [31:0]             req_rdata,
   output logic [NUM_REQ-1:0]      req_error,
   output logic                    out_ren,
   output logic                    out_wen,
   output logic [31:0]             out_addr,
   output logic [31:0]             out_wdata,
   output logic [3:0]              out_byte_en,
   input  logic                    out_busy,
   input  logic [31:0]             out_rdata,
   input  logic                    out_error,
   output logic                    grant_valid,
   output logic [ID_W-1:0]         grant_id
);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t            state;
   logic [ID_W-1:0]   owner;
   logic [ID_W-1:0]   last;
   logic [NUM_REQ-1:0] active;
   logic              found;
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   sel;
   logic              gv;
   logic              abort;

   assign active = req_ren | req_wen;

   // Search starts just past the last completed/aborted grant.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && active[idx]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   assign sel   = (state == OWNED) ? owner : win;
   assign gv    = nRST && ((state == OWNED) || found);
   assign abort = gv && (state == OWNED) && !active[owner];

   assign grant_valid = gv;
   assign grant_id    = gv ? sel : '0;
   assign req_rdata   = out_rdata;

   assign out_ren     = gv && !abort && req_ren[sel];
   assign out_wen     = gv && !abort && req_wen[sel];
   assign out_addr    = gv ? req_addr[int'(sel)*32 +: 32] : '0;
   assign out_wdata   = gv ? req_wdata[int'(sel)*32 +: 32] : '0;
   assign out_byte_en = gv ? req_byte_en[int'(sel)*4 +: 4] : '0;

   always_comb begin
      req_busy  = '1;
      req_error = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gv && sel == ID_W'(i)) begin
            req_busy[i]  = abort || out_busy;
            req_error[i] = out_error;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         owner <= '0;
         last  <= ID_W'(NUM_REQ - 1);
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  if (!out_busy) begin
                     last <= win;
                  end else begin
                     state <= OWNED;
                     owner <= win;
                  end
               end
            end
            OWNED: begin
               if (abort || !out_busy) begin
                  state <= IDLE;
                  last  <= owner;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Directed and randomized checks of generic_bus_arbiter against a
// transaction-level round-robin reference model.
module tb_generic_bus_arbiter;

   localparam int N = 2;

   logic          CLK;
   logic          nRST;
   logic [N-1:0]  req_ren, req_wen;
   logic [N*32-1:0] req_addr, req_wdata;
   logic [N*4-1:0]  req_byte_en;
   logic [N-1:0]  req_busy, req_error;
   logic [31:0]   req_rdata;
   logic          out_ren, out_wen;
   logic [31:0]   out_addr, out_wdata;
   logic [3:0]    out_byte_en;
   logic          out_busy, out_error;
   logic [31:0]   out_rdata;
   logic          grant_valid;
   logic [0:0]    grant_id;

   generic_bus_arbiter #(.NUM_REQ(N)) dut (
      .CLK(CLK), .nRST(nRST),
      .req_ren(req_ren), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_byte_en(req_byte_en),
      .req_busy(req_busy), .req_rdata(req_rdata),
      .req_error(req_error),
      .out_ren(out_ren), .out_wen(out_wen),
      .out_addr(out_addr), .out_wdata(out_wdata),
      .out_byte_en(out_byte_en),
      .out_busy(out_busy), .out_rdata(out_rdata),
      .out_error(out_error),
      .grant_valid(grant_valid), .grant_id(grant_id)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int ncmp = 0;
   int nerr = 0;
   // Model: holder is the requester with a transaction in flight (-1 none).
   int holder = -1;
   int last   = N - 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setreq(input int i, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
      req_ren[i] = r;
      req_wen[i] = w;
      req_addr[32*i +: 32]  = a;
      req_wdata[32*i +: 32] = d;
      req_byte_en[4*i +: 4] = b;
   endtask

   // Check one cycle against the model, advance the model, wait to negedge.
   task automatic cyc();
      logic [N-1:0] act;
      int win, id, idx;
      bit gv, ab;
      logic [N-1:0] e_busy, e_err;
      #1;
      if (!nRST) begin
         holder = -1;
         last   = N - 1;
      end
      act = req_ren | req_wen;
      win = -1;
      if (nRST && holder < 0)
         for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (win < 0 && act[idx]) win = idx;
         end
      id = (holder >= 0) ? holder : ((win >= 0) ? win : 0);
      gv = nRST && (holder >= 0 || win >= 0);
      ab = gv && holder >= 0 && !act[holder];
      e_busy = '1;
      e_err  = '0;
      if (gv && !ab && !out_busy) e_busy[id] = 1'b0;
      if (gv) e_err[id] = out_error;
      chk("grant_valid", grant_valid, gv);
      chk("grant_id", grant_id, gv ? id : 0);
      chk("out_ren", out_ren, gv && !ab && req_ren[id]);
      chk("out_wen", out_wen, gv && !ab && req_wen[id]);
      chk("out_addr", out_addr, gv ? req_addr[32*id +: 32] : 0);
      chk("out_wdata", out_wdata, gv ? req_wdata[32*id +: 32] : 0);
      chk("out_byte_en", out_byte_en, gv ? req_byte_en[4*id +: 4] : 0);
      chk("req_busy", req_busy, e_busy);
      chk("req_error", req_error, e_err);
      chk("req_rdata", req_rdata, out_rdata);
      if (nRST) begin
         if (holder < 0 && win >= 0) begin
            if (!out_busy) last = win;
            else holder = win;
         end else if (holder >= 0 && (ab || !out_busy)) begin
            last   = holder;
            holder = -1;
         end
      end
      @(negedge CLK);
   endtask

   initial begin
      nRST = 1'b0;
      req_ren = '0; req_wen = '0;
      req_addr = '0; req_wdata = '0; req_byte_en = '0;
      out_busy = 1'b0; out_error = 1'b0; out_rdata = '0;
      // Reset state with an active request that must be masked
      setreq(0, 1, 0, 32'h100, 32'h0, 4'hF);
      #1;
      chk("rst_gv", grant_valid, 0);
      chk("rst_busy", req_busy, 2'b11);
      chk("rst_ren", out_ren, 0);
      cyc();
      nRST = 1'b1;

      // Single read, slave busy for two cycles
      out_busy = 1'b1;
      out_rdata = 32'hDEADBEEF;
      cyc();
      cyc();
      out_busy = 1'b0;
      #1;
      chk("read_busy", req_busy, 2'b10);
      chk("read_rdata", req_rdata, 32'hDEADBEEF);
      cyc();
      setreq(0, 0, 0, 0, 0, 0);
      cyc();

      // Contention from a fresh reset
      nRST = 1'b0;
      cyc();
      nRST = 1'b1;
      setreq(0, 1, 0, 32'h200, 32'h0, 4'hF);
      setreq(1, 1, 0, 32'h300, 32'h0, 4'h3);
      #1;
      chk("cont_first", grant_id, 0);
      for (int t = 0; t < 4; t++) begin
         out_busy = 1'b1;
         cyc();
         out_busy = 1'b0;
         #1;
         chk("cont_alt", grant_id, t % 2);
         cyc();
      end
      setreq(0, 0, 0, 0, 0, 0);
      setreq(1, 0, 0, 0, 0, 0);
      cyc();

      // Late arrival, then error on requester 1's write
      setreq(0, 1, 0, 32'h400, 32'h0, 4'hF);
      out_busy = 1'b1;
      cyc();
      setreq(1, 0, 1, 32'h500, 32'h55AA, 4'hC);
      #1;
      chk("late_wen", out_wen, 0);
      chk("late_addr", out_addr, 32'h400);
      cyc();
      out_busy = 1'b0;
      cyc();
      setreq(0, 0, 0, 0, 0, 0);
      out_error = 1'b1;
      #1;
      chk("late_gid", grant_id, 1);
      chk("err_vec", req_error, 2'b10);
      cyc();
      out_error = 1'b0;
      setreq(1, 0, 0, 0, 0, 0);
      cyc();

      // Abort by requester 0 while a request from 1 pends
      setreq(0, 1, 0, 32'h600, 32'h0, 4'hF);
      out_busy = 1'b1;
      cyc();
      setreq(1, 1, 0, 32'h700, 32'h0, 4'hF);
      cyc();
      setreq(0, 0, 0, 32'h600, 32'h0, 4'hF);
      #1;
      chk("abort_ren", out_ren, 0);
      chk("abort_busy", req_busy, 2'b11);
      cyc();
      out_busy = 1'b0;
      #1;
      chk("abort_next", grant_id, 1);
      cyc();
      setreq(1, 0, 0, 0, 0, 0);
      cyc();

      // Reset while owned
      setreq(0, 1, 0, 32'h800, 32'h0, 4'hF);
      out_busy = 1'b1;
      cyc();
      cyc();
      #2 nRST = 1'b0;
      #1;
      chk("mid_rst_ren", out_ren, 0);
      chk("mid_rst_busy", req_busy, 2'b11);
      cyc();
      nRST = 1'b1;
      setreq(1, 1, 0, 32'h900, 32'h0, 4'hF);
      #1;
      chk("post_rst_gid", grant_id, 0);
      cyc();

      // Randomized traffic
      for (int t = 0; t < 600; t++) begin
         nRST = ($urandom_range(0, 99) != 0);
         for (int i = 0; i < N; i++) begin
            if (req_ren[i] | req_wen[i]) begin
               if ($urandom_range(0, 9) == 0) setreq(i, 0, 0, 0, 0, 0);
            end else if ($urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 1) == 1)
                  setreq(i, 1, 0, $urandom, $urandom, 4'($urandom));
               else
                  setreq(i, 0, 1, $urandom, $urandom, 4'($urandom));
            end
         end
         out_busy  = $urandom_range(0, 1) == 1;
         out_error = $urandom_range(0, 3) == 0;
         out_rdata = $urandom;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
